// File: rtl/kp_color_threshold.sv
// kp_color_threshold
//   Colour-detection stage fed by the R/G/B Gaussian output buffers. Reads one
//   sample per channel in lock-step, tests each pixel against inclusive
//   per-channel [min, max] windows and writes a mask byte (0xFF match, 0x00 no
//   match) into a downstream FIFO. Counts matching pixels per frame and
//   publishes the count when the frame's last pixel is written.
//
// Ports
//   i_clk, i_rstn            clock, asynchronous active-low reset
//   i_enable                 1 = issue reads, 0 = stop reading and drain
//   i_flush                  synchronous clear of pipeline and frame counters
//   i_{r,g,b}_data           channel read data, valid the cycle after rd
//   i_{r,g,b}_almostempty    channel buffer almost-empty flags
//   o_{r,g,b}_rd             channel read strobes (always identical)
//   i_{r,g,b}_{min,max}      inclusive thresholds, quasi-static
//   i_almostfull             downstream FIFO almost-full
//   o_wr, o_data             downstream FIFO write strobe and mask byte
//   o_frame_done             pulse with the write of a frame's last pixel
//   o_match_count            matching pixels in the last completed frame
module kp_color_threshold #(
  parameter int FRAME_PIXELS = 307200,
  parameter int CNT_WIDTH    = 19
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_enable,
  input  logic                 i_flush,
  input  logic [7:0]           i_r_data,
  input  logic [7:0]           i_g_data,
  input  logic [7:0]           i_b_data,
  input  logic                 i_r_almostempty,
  input  logic                 i_g_almostempty,
  input  logic                 i_b_almostempty,
  output logic                 o_r_rd,
  output logic                 o_g_rd,
  output logic                 o_b_rd,
  input  logic [7:0]           i_r_min,
  input  logic [7:0]           i_r_max,
  input  logic [7:0]           i_g_min,
  input  logic [7:0]           i_g_max,
  input  logic [7:0]           i_b_min,
  input  logic [7:0]           i_b_max,
  input  logic                 i_almostfull,
  output logic                 o_wr,
  output logic [7:0]           o_data,
  output logic                 o_frame_done,
  output logic [CNT_WIDTH-1:0] o_match_count
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_PIX = CNT_WIDTH'(FRAME_PIXELS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // Unsigned inclusive window test; an inverted window (lo > hi) can never hold.
  function automatic logic in_window(input logic [7:0] x,
                                     input logic [7:0] lo,
                                     input logic [7:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

  state_t               state;
  logic                 rd_p0;
  logic                 vld_p1;
  logic                 wr_p2;
  logic [7:0]           data_p2;
  logic                 done_p2;
  logic [CNT_WIDTH-1:0] pix_cnt;
  logic [CNT_WIDTH-1:0] match_acc;
  logic [CNT_WIDTH-1:0] match_count;
  logic                 go;
  logic                 match_p1;

  // A single almost-empty channel stalls all three so the channels stay aligned.
  assign go = i_enable & ~i_r_almostempty & ~i_g_almostempty & ~i_b_almostempty
            & ~i_almostfull;

  assign match_p1 = in_window(i_r_data, i_r_min, i_r_max)
                  & in_window(i_g_data, i_g_min, i_g_max)
                  & in_window(i_b_data, i_b_min, i_b_max);

  // ---- stage p0: read issue ----
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      rd_p0 <= 1'b0;
    end else if (i_flush) begin
      state <= IDLE;
      rd_p0 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            rd_p0 <= 1'b1;
            state <= ACTIVE;
          end else begin
            rd_p0 <= 1'b0;
          end
        end
        ACTIVE: begin
          rd_p0 <= go;
          if (!go) state <= IDLE;
        end
        default: begin
          rd_p0 <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // ---- stage p1: channel data valid ----
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_p1 <= 1'b0;
    end else if (i_flush) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_p0;
    end
  end

  // ---- stage p2: mask write and frame accounting ----
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_p2       <= 1'b0;
      data_p2     <= 8'h00;
      done_p2     <= 1'b0;
      pix_cnt     <= '0;
      match_acc   <= '0;
      match_count <= '0;
    end else if (i_flush) begin
      // The published count of the last completed frame survives a flush.
      wr_p2     <= 1'b0;
      done_p2   <= 1'b0;
      pix_cnt   <= '0;
      match_acc <= '0;
    end else begin
      wr_p2   <= vld_p1;
      done_p2 <= 1'b0;
      if (vld_p1) begin
        data_p2 <= match_p1 ? 8'hFF : 8'h00;
        if (pix_cnt == LAST_PIX) begin
          done_p2     <= 1'b1;
          match_count <= match_acc + (match_p1 ? CNT_ONE : '0);
          pix_cnt     <= '0;
          match_acc   <= '0;
        end else begin
          pix_cnt   <= pix_cnt + CNT_ONE;
          match_acc <= match_acc + (match_p1 ? CNT_ONE : '0);
        end
      end
    end
  end

  assign o_r_rd        = rd_p0;
  assign o_g_rd        = rd_p0;
  assign o_b_rd        = rd_p0;
  assign o_wr          = wr_p2;
  assign o_data        = data_p2;
  assign o_frame_done  = done_p2;
  assign o_match_count = match_count;

endmodule
